// File: rtl/sample_queue_pkg.sv
// Shared types and default sizing for the stereo sample queue.
// Contents: state_t (IDLE/SEQ), stereo_t sample payload, default DEPTH/TAPS.
package sample_queue_pkg;

    localparam int unsigned DEPTH_DEF = 1024;
    localparam int unsigned TAPS_DEF  = 1021;
    localparam int unsigned SMPL_W    = 16;

    typedef enum logic {
        IDLE = 1'b0,
        SEQ  = 1'b1
    } state_t;

    // One stereo sample as stored in the RAM (left in the upper half).
    typedef struct packed {
        logic [SMPL_W-1:0] lft;
        logic [SMPL_W-1:0] rght;
    } stereo_t;

endpackage

// File: rtl/sample_queue_if.sv
// Sample queue bus: write strobe + stereo sample in, burst data + status out.
// master: sample producer / filter side; slave: the queue itself.
interface sample_queue_if;
    import sample_queue_pkg::*;

    logic              wrt_smpl;
    logic [SMPL_W-1:0] lft_smpl;
    logic [SMPL_W-1:0] rght_smpl;
    logic              sequencing;
    logic [SMPL_W-1:0] lft_out;
    logic [SMPL_W-1:0] rght_out;
    logic              overrun;

    modport master (
        output wrt_smpl, lft_smpl, rght_smpl,
        input  sequencing, lft_out, rght_out, overrun
    );

    modport slave (
        input  wrt_smpl, lft_smpl, rght_smpl,
        output sequencing, lft_out, rght_out, overrun
    );

endinterface

// File: rtl/dp_ram_stereo.sv
// DEPTH x 32 stereo sample RAM: one write port, one synchronous read port
// with 1-cycle latency. rd_data is a register that holds while rd_en is low.
// Ports: clk, rst_n, wr_en/wr_addr/wr_data, rd_en/rd_addr, rd_data.
// SAMPLE_QUEUE_ZERO_FILL_EN: per-entry valid bits make unwritten entries read 0.
module dp_ram_stereo
    import sample_queue_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  stereo_t                  wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output stereo_t                  rd_data
);

    stereo_t mem [DEPTH];

    // Storage array, no reset (contents undefined after reset).
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

`ifdef SAMPLE_QUEUE_ZERO_FILL_EN
    logic [DEPTH-1:0] vld;

    // Valid bit per entry so never-written locations read as silence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
        end else if (wr_en) begin
            vld[wr_addr] <= 1'b1;
        end
    end

    // Registered read port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= vld[rd_addr] ? mem[rd_addr] : '0;
        end
    end
`else
    // Registered read port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end
`endif

endmodule

// File: rtl/sample_queue.sv
// Stereo circular sample queue. Stores incoming samples and, once TAPS samples
// are held, replays the last TAPS of them oldest-first as a TAPS+1 cycle burst
// (cycle 0 is the RAM read latency slot).
// Ports: clk, rst_n, bus (sample_queue_if.slave: wrt_smpl, lft_smpl,
// rght_smpl in; sequencing, lft_out, rght_out, overrun out).
// Macro SAMPLE_QUEUE_ZERO_FILL_EN: queue starts full of zeros, so the first
// write already triggers a burst.
module sample_queue
    import sample_queue_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned TAPS  = TAPS_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    sample_queue_if.slave  bus
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(TAPS + 1);

`ifdef SAMPLE_QUEUE_ZERO_FILL_EN
    // Pretend TAPS zero samples precede address 0, so the oldest sits TAPS
    // entries behind the write pointer.
    localparam logic [CW-1:0] FILL_RST = CW'(TAPS);
    localparam logic [AW-1:0] OLD_RST  = AW'(DEPTH - TAPS);
`else
    localparam logic [CW-1:0] FILL_RST = '0;
    localparam logic [AW-1:0] OLD_RST  = '0;
`endif

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   burst_cnt;
    logic [CW-1:0]   burst_cnt_nxt;
    logic [CW-1:0]   fill_cnt;
    logic [AW-1:0]   new_ptr;
    logic [AW-1:0]   old_ptr;
    logic            seq_q;
    logic            ovr_q;
    logic            wr_en_c;
    logic            rd_en_c;
    logic [AW-1:0]   rd_addr_c;
    stereo_t         wr_data_c;
    stereo_t         rd_data;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            burst_cnt <= '0;
            seq_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            burst_cnt <= burst_cnt_nxt;
            seq_q     <= (state_nxt == SEQ);
        end
    end

    // Next state, write accept and read issue. Read for cycle c+1 is issued
    // in cycle c, so reads run for c = 0..TAPS-1 and stop on the last cycle.
    always_comb begin
        state_nxt     = state;
        burst_cnt_nxt = burst_cnt;
        wr_en_c       = 1'b0;
        rd_en_c       = 1'b0;
        rd_addr_c     = old_ptr + AW'(burst_cnt);
        case (state)
            IDLE: begin
                burst_cnt_nxt = '0;
                if (bus.wrt_smpl) begin
                    wr_en_c = 1'b1;
                    if (fill_cnt >= CW'(TAPS - 1)) begin
                        state_nxt = SEQ;
                    end
                end
            end
            SEQ: begin
                if (burst_cnt == CW'(TAPS)) begin
                    state_nxt = IDLE;
                end else begin
                    rd_en_c       = 1'b1;
                    burst_cnt_nxt = burst_cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Write/oldest pointers and saturating fill count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            new_ptr  <= '0;
            old_ptr  <= OLD_RST;
            fill_cnt <= FILL_RST;
        end else if (wr_en_c) begin
            new_ptr <= new_ptr + AW'(1);
            if (fill_cnt == CW'(TAPS)) begin
                old_ptr <= old_ptr + AW'(1);
            end else begin
                fill_cnt <= fill_cnt + CW'(1);
            end
        end
    end

    // Sticky overrun: any strobe while bursting, including the last cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_q <= 1'b0;
        end else if (bus.wrt_smpl && (state == SEQ)) begin
            ovr_q <= 1'b1;
        end
    end

    assign wr_data_c = {bus.lft_smpl, bus.rght_smpl};

    dp_ram_stereo #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en_c),
        .wr_addr (new_ptr),
        .wr_data (wr_data_c),
        .rd_en   (rd_en_c),
        .rd_addr (rd_addr_c),
        .rd_data (rd_data)
    );

    assign bus.sequencing = seq_q;
    assign bus.overrun    = ovr_q;
    assign bus.lft_out    = rd_data.lft;
    assign bus.rght_out   = rd_data.rght;

endmodule

// File: tb/tb_sample_queue.sv
// Bench for sample_queue at a reduced size (DEPTH=16, TAPS=13) so the
// wrap and repeated-burst scenarios stay short.
module tb_sample_queue;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned TAPS  = 13;

    logic clk;
    logic rst_n;

    sample_queue_if bus ();

    sample_queue #(
        .DEPTH (DEPTH),
        .TAPS  (TAPS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [31:0] hist[$];
    logic [31:0] sb[$];
    bit          m_seq;
    int          m_cnt;
    bit          m_ovr;

    // Monitor state
    logic [31:0] m_last;
    int          run_len;
    logic [31:0] cap_first;
    logic [31:0] cap_lastv;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        sb.delete();
`ifdef SAMPLE_QUEUE_ZERO_FILL_EN
        for (int i = 0; i < int'(TAPS); i++) hist.push_back(32'h0);
`endif
        m_seq = 1'b0;
        m_cnt = 0;
        m_ovr = 1'b0;
    endtask

    // Behavioral queue model: sample history + expected burst scoreboard.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else if (m_seq) begin
            if (bus.wrt_smpl) m_ovr = 1'b1;
            if (m_cnt == int'(TAPS)) m_seq = 1'b0;
            else m_cnt++;
        end else if (bus.wrt_smpl) begin
            hist.push_back({bus.lft_smpl, bus.rght_smpl});
            if (hist.size() > int'(TAPS)) void'(hist.pop_front());
            if (hist.size() == int'(TAPS)) begin
                m_seq = 1'b1;
                m_cnt = 0;
                foreach (hist[i]) sb.push_back(hist[i]);
            end
        end
    end

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_last  = 32'h0;
            run_len = 0;
        end else begin
            chk("sequencing", {31'h0, bus.sequencing}, {31'h0, m_seq});
            chk("overrun", {31'h0, bus.overrun}, {31'h0, m_ovr});
            if (m_seq && m_cnt >= 1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: got data %h expected none", {bus.lft_out, bus.rght_out});
                end else begin
                    m_last = sb.pop_front();
                    chk("burst_data", {bus.lft_out, bus.rght_out}, m_last);
                end
                if (m_cnt == 1) cap_first = {bus.lft_out, bus.rght_out};
                if (m_cnt == int'(TAPS)) cap_lastv = {bus.lft_out, bus.rght_out};
            end else if (!m_seq) begin
                chk("idle_hold", {bus.lft_out, bus.rght_out}, m_last);
            end
            if (bus.sequencing) begin
                run_len++;
            end else if (run_len != 0) begin
                chk("burst_len", 32'(run_len), 32'(TAPS + 1));
                run_len = 0;
            end
        end
    end

    // One-cycle write strobe; called and returns on a falling edge.
    task automatic pulse(input logic [15:0] l, input logic [15:0] r);
        bus.lft_smpl  = l;
        bus.rght_smpl = r;
        bus.wrt_smpl  = 1'b1;
        @(negedge clk);
        bus.wrt_smpl  = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (m_seq && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle_timeout", {31'h0, m_seq}, 32'h0);
    endtask

    task automatic wait_burst_cycle(input int k);
        int n = 0;
        while (!(m_seq && m_cnt == k) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("wait_cycle_timeout", 32'(m_cnt), 32'(k));
    endtask

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        int          hit;      // burst cycle for an extra (dropped) strobe, 0 = none
        logic        exp_ovr;  // overrun expected after the vector
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{l: 16'h8000, r: 16'h7FFF, hit: 0,        exp_ovr: 1'b0};
        vecs[1] = '{l: 16'h0001, r: 16'hFFFF, hit: 0,        exp_ovr: 1'b0};
        vecs[2] = '{l: 16'h1234, r: 16'hABCD, hit: 6,        exp_ovr: 1'b1};
        vecs[3] = '{l: 16'h7FFF, r: 16'h8000, hit: int'(TAPS), exp_ovr: 1'b1};
        vecs[4] = '{l: 16'hAAAA, r: 16'h5555, hit: 0,        exp_ovr: 1'b1};

        cap_first     = '0;
        cap_lastv     = '0;
        bus.wrt_smpl  = 1'b0;
        bus.lft_smpl  = '0;
        bus.rght_smpl = '0;
        rst_n         = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sequencing", {31'h0, bus.sequencing}, 32'h0);
        chk("rst_overrun", {31'h0, bus.overrun}, 32'h0);
        chk("rst_out", {bus.lft_out, bus.rght_out}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Fill with n = 1..TAPS: burst delivers 1 first and TAPS last.
        for (int n = 1; n <= int'(TAPS); n++) begin
            wait_idle();
            pulse(16'(n), 16'(n));
        end
        wait_idle();
        chk("fill_first", cap_first, {16'd1, 16'd1});
        chk("fill_last", cap_lastv, {16'(TAPS), 16'(TAPS)});

        // Keep writing past DEPTH, each followed by a full burst.
        for (int n = int'(TAPS) + 1; n <= int'(DEPTH) + 4; n++) begin
            pulse(16'(n), 16'(n));
            wait_idle();
        end
        chk("wrap_first", cap_first, {16'(DEPTH + 5 - TAPS), 16'(DEPTH + 5 - TAPS)});
        chk("wrap_last", cap_lastv, {16'(DEPTH + 4), 16'(DEPTH + 4)});

        // Table vectors: polarity extremes and overrun strobes.
        foreach (vecs[i]) begin
            pulse(vecs[i].l, vecs[i].r);
            if (vecs[i].hit > 0) begin
                wait_burst_cycle(vecs[i].hit);
                pulse(~vecs[i].l, ~vecs[i].r);
            end
            wait_idle();
            @(negedge clk);
            chk("vec_overrun", {31'h0, bus.overrun}, {31'h0, vecs[i].exp_ovr});
            chk("vec_newest", cap_lastv, {vecs[i].l, vecs[i].r});
        end

        // Reset in the middle of a burst.
        pulse(16'h4444, 16'h5555);
        wait_burst_cycle(7);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_sequencing", {31'h0, bus.sequencing}, 32'h0);
        chk("abort_out", {bus.lft_out, bus.rght_out}, 32'h0);
        chk("abort_overrun", {31'h0, bus.overrun}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_sequencing", {31'h0, bus.sequencing}, 32'h0);

        for (int n = 0; n < int'(TAPS) - 1; n++) begin
            wait_idle();
            pulse(16'(100 + n), 16'(200 + n));
        end
        wait_idle();
`ifndef SAMPLE_QUEUE_ZERO_FILL_EN
        @(negedge clk);
        chk("no_early_burst", {31'h0, bus.sequencing}, 32'h0);
`endif
        pulse(16'h0F0F, 16'hF0F0);
        wait_idle();
        @(negedge clk);
        chk("refill_newest", cap_lastv, {16'h0F0F, 16'hF0F0});
        chk("sb_drained", 32'(sb.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
